mul4_rr_arbiter: RTL
====================

// Module: mul4_rr_arbiter
// PURPOSE
//  Shares one 4x4 unsigned combinational array multiplier (existing team block) among NREQ requesters.
//  Round-robin arbitration, valid/ready handshakes on every requester and on the result port.
//  Registered result with requester ID; one multiply accepted per cycle at full throughput.
//  Sits between operand producers and a single result consumer.
// PARAMETERS
//  NREQ  4  number of requesters, 2..8
//  IDW   2  width of res_id; must equal clog2(NREQ), minimum 1
// PORTS
//  clk        in   1        rising-edge clock
//  rst_n      in   1        asynchronous reset, active low
//  req_valid  in   NREQ     requester i has an operand pair
//  req_a      in   4*NREQ   operand a of requester i at [4i+3:4i]
//  req_b      in   4*NREQ   operand b of requester i at [4i+3:4i]
//  req_ready  out  NREQ     one-hot or zero; requester i accepted this cycle
//  res_valid  out  1        res_p/res_id hold a result
//  res_p      out  8        product a*b, unsigned
//  res_id     out  IDW      index of the requester that produced res_p
//  res_ready  in   1        consumer takes the result this cycle
//  busy_cnt   out  16       count of accepted multiplies since reset
// BEHAVIOUR
//  Reset (rst_n=0, async): res_valid=0, res_p=0, res_id=0, busy_cnt=0, rr_ptr=0, state=EMPTY.
//  req_ready is combinational from req_valid, rr_ptr and state; no combinational path from req_a/req_b.
//  Output register FSM, 2 states:
//   EMPTY: res_valid=0. Any req_valid -> accept winner, load result, go FULL.
//   FULL:  res_valid=1. res_ready=0 -> hold res_p/res_id stable, req_ready all 0.
//          res_ready=1 and some req_valid -> drain and reload same edge, stay FULL.
//          res_ready=1 and no req_valid -> go EMPTY.
//  can_accept = (state==EMPTY) | res_ready.
//  Arbitration: scan indices rr_ptr, rr_ptr+1, ..., mod NREQ; first with req_valid=1 wins.
//   req_ready[win]=can_accept; all other req_ready bits 0.
//   On acceptance: rr_ptr <= (win+1) mod NREQ; otherwise rr_ptr unchanged.
//  Transfer on requester i = req_valid[i] & req_ready[i]; result transfer = res_valid & res_ready.
//  Latency: operands accepted at edge N appear on res_p/res_id from edge N, i.e. res_valid seen
//   in the cycle after acceptance. Back-to-back throughput 1/cycle while res_ready=1.
//  Arithmetic: res_p = {4'b0,a} * {4'b0,b}, 8-bit, never overflows (max 15*15=225).
//  busy_cnt increments by 1 per accepted request; wraps 16'hFFFF -> 0.
//  Requesters may drop req_valid without a transfer; no request is latched until accepted.
//  Reset mid-operation: pending result discarded, res_valid drops immediately, rr_ptr=0.
//  res_ready while res_valid=0 is ignored.
//  res_id for NREQ not a power of 2: only values 0..NREQ-1 ever driven.
// TESTING
//  1. Reset, req0 a=5 b=2, res_ready=1 -> req_ready=0001, next cycle res_valid=1 res_p=10 res_id=0.
//  2. All four valid continuously (a=i+1,b=3), res_ready=1 -> grants 0,1,2,3,0 on successive cycles;
//     res_p 3,6,9,12,3; busy_cnt=5.
//  3. FULL with res_ready=0 for 3 cycles, req2 a=15 b=15 valid -> req_ready=0, res_p/res_id stable;
//     raise res_ready -> req2 accepted, next res_p=225 res_id=2.
//  4. rr_ptr=2, req0 and req3 valid -> req3 granted first, then req0 (rr_ptr wraps 3->0).
//  5. Assert rst_n=0 mid-stream with res_valid=1 -> res_valid=0, busy_cnt=0 without clock edge;
//     after release req1 wins over req0 only if rr_ptr scan says so (rr_ptr=0 -> req0 first).
//  6. Exhaustive: random requesters, all 256 a/b pairs, random res_ready -> every res_p equals
//     a*b of the tagged requester's accepted pair, in acceptance order, no loss or duplication.

Source files
------------

// File: rtl/mul4_rr_arbiter.sv
// Round-robin arbiter sharing one 4x4 unsigned array multiplier among NREQ requesters,
// with a registered result stage (valid/ready) tagged by requester index.

module mul4_array (
    input  logic [3:0] a,
    input  logic [3:0] b,
    output logic [7:0] p
);

    logic [7:0] acc_s;

    // Shift-and-add of the four partial-product rows.
    always_comb begin
        acc_s = 8'd0;
        for (int i = 0; i < 4; i++) begin
            if (b[i]) begin
                acc_s = acc_s + ({4'd0, a} << i);
            end else begin
                acc_s = acc_s;
            end
        end
        p = acc_s;
    end

endmodule

module mul4_rr_arbiter #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [4*NREQ-1:0] req_a,
    input  logic [4*NREQ-1:0] req_b,
    output logic [NREQ-1:0]   req_ready,
    output logic              res_valid,
    output logic [7:0]        res_p,
    output logic [IDW-1:0]    res_id,
    input  logic              res_ready,
    output logic [15:0]       busy_cnt
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t         state_r;
    logic [IDW-1:0] rr_ptr_r;
    logic [IDW-1:0] win_s;
    logic [IDW-1:0] nxt_ptr_s;
    logic           any_s;
    logic           can_accept_s;
    logic           accept_s;
    logic [3:0]     sel_a_s;
    logic [3:0]     sel_b_s;
    logic [7:0]     prod_s;
    logic           res_valid_r;
    logic [7:0]     res_p_r;
    logic [IDW-1:0] res_id_r;
    logic [15:0]    busy_cnt_r;

    // Scan requesters starting at rr_ptr; the first valid one wins.
    always_comb begin
        logic [IDW-1:0] idx_v;
        win_s = {IDW{1'b0}};
        any_s = 1'b0;
        idx_v = {IDW{1'b0}};
        for (int k = 0; k < NREQ; k++) begin
            idx_v = IDW'((int'(rr_ptr_r) + k) % NREQ);
            if (!any_s && req_valid[idx_v]) begin
                any_s = 1'b1;
                win_s = idx_v;
            end else begin
                any_s = any_s;
            end
        end
    end

    assign can_accept_s = (state_r == EMPTY) | res_ready;
    assign accept_s     = any_s & can_accept_s;
    assign nxt_ptr_s    = (win_s == IDW'(NREQ - 1)) ? {IDW{1'b0}} : (win_s + IDW'(1'b1));

    // Grant is one-hot on the winner, gated by the output stage being able to take a result.
    always_comb begin
        req_ready = {NREQ{1'b0}};
        if (accept_s) begin
            req_ready[win_s] = 1'b1;
        end else begin
            req_ready = {NREQ{1'b0}};
        end
    end

    // Operand mux feeding the shared multiplier.
    always_comb begin
        sel_a_s = 4'd0;
        sel_b_s = 4'd0;
        for (int k = 0; k < NREQ; k++) begin
            if (win_s == IDW'(k)) begin
                sel_a_s = req_a[4*k +: 4];
                sel_b_s = req_b[4*k +: 4];
            end else begin
                sel_a_s = sel_a_s;
                sel_b_s = sel_b_s;
            end
        end
    end

    mul4_array u_mul (
        .a (sel_a_s),
        .b (sel_b_s),
        .p (prod_s)
    );

    // Output-register FSM plus round-robin pointer and acceptance counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= EMPTY;
            res_valid_r <= 1'b0;
            res_p_r     <= 8'd0;
            res_id_r    <= {IDW{1'b0}};
            rr_ptr_r    <= {IDW{1'b0}};
            busy_cnt_r  <= 16'd0;
        end else begin
            case (state_r)
                EMPTY: begin
                    if (accept_s) begin
                        state_r     <= FULL;
                        res_valid_r <= 1'b1;
                        res_p_r     <= prod_s;
                        res_id_r    <= win_s;
                    end else begin
                        state_r     <= EMPTY;
                        res_valid_r <= 1'b0;
                    end
                end
                FULL: begin
                    if (accept_s) begin
                        // Drain and reload on the same edge.
                        state_r     <= FULL;
                        res_valid_r <= 1'b1;
                        res_p_r     <= prod_s;
                        res_id_r    <= win_s;
                    end else if (res_ready) begin
                        state_r     <= EMPTY;
                        res_valid_r <= 1'b0;
                    end else begin
                        state_r     <= FULL;
                        res_valid_r <= 1'b1;
                    end
                end
                default: begin
                    state_r     <= EMPTY;
                    res_valid_r <= 1'b0;
                end
            endcase

            if (accept_s) begin
                rr_ptr_r   <= nxt_ptr_s;
                busy_cnt_r <= busy_cnt_r + 16'd1;
            end else begin
                rr_ptr_r   <= rr_ptr_r;
                busy_cnt_r <= busy_cnt_r;
            end
        end
    end

    assign res_valid = res_valid_r;
    assign res_p     = res_p_r;
    assign res_id    = res_id_r;
    assign busy_cnt  = busy_cnt_r;

endmodule
